// File: rtl/mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mem_scheduler
// Description : Arbitrates icache and load/store word requests onto the single
//               byte-wide RAM/IO port, serialising each request into bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_scheduler #(
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic c_own_ic = 1'b0;
  localparam logic c_own_ls = 1'b1;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_base, w_base_nx;
  logic [2:0]        r_n, w_n_nx;
  logic [2:0]        r_cap, w_cap_nx;
  logic              r_pend, w_pend_nx;
  logic              r_owner, w_owner_nx;
  logic              r_last, w_last_nx;
  logic [31:0]       r_wdata, w_wdata_nx;
  logic [31:0]       r_asm, w_asm_nx;
  logic [31:0]       r_ic_data, w_ic_data_nx;
  logic [31:0]       r_ls_rdata, w_ls_rdata_nx;
  logic              r_ic_done, w_ic_done_nx;
  logic              r_ls_done, w_ls_done_nx;

  logic [2:0]        w_ls_n;
  logic              w_ic_vld, w_ls_vld, w_grant_ls, w_grant_ic;
  logic [2:0]        w_cap_inc, w_rd_aidx, w_aidx;
  logic              w_rd_last, w_stall, w_mem_wr;
  logic [ADDR_W-1:0] w_cur_addr;

  assign ic_done  = r_ic_done & rdy;
  assign ls_done  = r_ls_done & rdy;
  assign ic_data  = r_ic_data;
  assign ls_rdata = r_ls_rdata;

  assign w_ls_n     = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
  assign w_ic_vld   = ic_req & ~ic_done;
  assign w_ls_vld   = ls_req & ~ls_done;
  assign w_grant_ls = w_ls_vld & (~w_ic_vld | (r_last == c_own_ic));
  assign w_grant_ic = w_ic_vld & ~w_grant_ls;

  // r_pend means the address driven last cycle returns its byte on mem_din now.
  // While frozen, mem_a points at the byte still owed so the data is valid on resume.
  assign w_cap_inc  = r_cap + {2'b00, r_pend};
  assign w_rd_last  = (w_cap_inc == r_n);
  assign w_rd_aidx  = w_rd_last ? (r_n - 3'd1) : w_cap_inc;
  assign w_aidx     = ((r_state == S_RD) && rdy) ? w_rd_aidx : r_cap;
  assign w_cur_addr = r_base + ADDR_W'(w_aidx);
  assign w_stall    = (w_cur_addr[17:16] == IO_SEL) & io_buffer_full;
  assign w_mem_wr   = (r_state == S_WR) & rdy & ~w_stall;

  assign mem_a    = w_cur_addr;
  assign mem_wr   = w_mem_wr;
  assign mem_dout = w_mem_wr ? r_wdata[8*r_cap[1:0] +: 8] : 8'h00;

  always_comb begin
    w_state_nx    = r_state;
    w_base_nx     = r_base;
    w_n_nx        = r_n;
    w_cap_nx      = r_cap;
    w_pend_nx     = r_pend;
    w_owner_nx    = r_owner;
    w_last_nx     = r_last;
    w_wdata_nx    = r_wdata;
    w_asm_nx      = r_asm;
    w_ic_data_nx  = r_ic_data;
    w_ls_rdata_nx = r_ls_rdata;
    w_ic_done_nx  = r_ic_done;
    w_ls_done_nx  = r_ls_done;
    if (rdy) begin
      w_ic_done_nx = 1'b0;
      w_ls_done_nx = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!flush && (w_grant_ls || w_grant_ic)) begin
            w_cap_nx  = 3'd0;
            w_pend_nx = 1'b0;
            w_asm_nx  = 32'h0;
            if (w_grant_ls) begin
              w_base_nx  = ls_addr;
              w_n_nx     = w_ls_n;
              w_owner_nx = c_own_ls;
              w_last_nx  = c_own_ls;
              w_wdata_nx = ls_wdata;
              w_state_nx = ls_we ? S_WR : S_RD;
            end else begin
              w_base_nx  = ic_addr;
              w_n_nx     = 3'd4;
              w_owner_nx = c_own_ic;
              w_last_nx  = c_own_ic;
              w_state_nx = S_RD;
            end
          end
        end
        S_RD: begin
          if (flush) begin
            w_state_nx = S_IDLE;
            w_pend_nx  = 1'b0;
          end else begin
            if (r_pend) w_asm_nx[8*r_cap[1:0] +: 8] = mem_din;
            w_cap_nx = w_cap_inc;
            if (w_rd_last) begin
              w_state_nx = S_IDLE;
              w_pend_nx  = 1'b0;
              if (r_owner == c_own_ic) begin
                w_ic_data_nx = w_asm_nx;
                w_ic_done_nx = 1'b1;
              end else begin
                w_ls_rdata_nx = w_asm_nx;
                w_ls_done_nx  = 1'b1;
              end
            end else begin
              w_pend_nx = 1'b1;
            end
          end
        end
        S_WR: begin
          // Stores are already committed, so flush never interrupts them.
          if (!w_stall) begin
            w_cap_nx = r_cap + 3'd1;
            if (r_cap == (r_n - 3'd1)) begin
              w_state_nx   = S_IDLE;
              w_ls_done_nx = 1'b1;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_n        <= 3'd0;
      r_cap      <= 3'd0;
      r_pend     <= 1'b0;
      r_owner    <= c_own_ic;
      r_last     <= c_own_ic;
      r_wdata    <= 32'h0;
      r_asm      <= 32'h0;
      r_ic_data  <= 32'h0;
      r_ls_rdata <= 32'h0;
      r_ic_done  <= 1'b0;
      r_ls_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_base     <= w_base_nx;
      r_n        <= w_n_nx;
      r_cap      <= w_cap_nx;
      r_pend     <= w_pend_nx;
      r_owner    <= w_owner_nx;
      r_last     <= w_last_nx;
      r_wdata    <= w_wdata_nx;
      r_asm      <= w_asm_nx;
      r_ic_data  <= w_ic_data_nx;
      r_ls_rdata <= w_ls_rdata_nx;
      r_ic_done  <= w_ic_done_nx;
      r_ls_done  <= w_ls_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_scheduler
// Description : Self-checking bench for mem_scheduler against a byte-array
//               memory model and per-transaction expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_scheduler;

  localparam int c_MEMSZ = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        flush = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'h0;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  logic [31:0] ls_addr = 32'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_done;
  logic [31:0] ls_rdata;

  mem_scheduler #(.IO_SEL(2'b11), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram     [c_MEMSZ];
  logic [7:0]  ref_mem [c_MEMSZ];
  logic [39:0] wr_log  [$];
  logic [31:0] a_lat = 32'h0;
  logic [31:0] last_ic = 32'h0;
  logic [31:0] last_ls = 32'h0;
  bit          writing = 1'b0;
  int          stray_wr = 0;
  int          n_total = 0;
  int          n_bad = 0;

  // IO and RAM share one small array; bits 17:16 keep the IO window distinct.
  function automatic int fold(input logic [31:0] a);
    return int'({a[17:16], a[11:0]});
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[fold(a)]     = v;
    ref_mem[fold(a)] = v;
  endtask

  // One request from issue to done; rdy_at<0 means rdy stays high, fl holds flush after grant.
  task automatic do_txn(input bit is_ic, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int full, input int rdy_at, input bit fl);
    int          n, k, cyc, idx;
    bit          seen, st, io;
    logic [31:0] exp;
    logic [31:0] trace [16];
    n  = is_ic ? 4 : ((size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4);
    st = !is_ic && we;
    io = st && (addr[17:16] == 2'b11);
    k  = st ? n + 1 : n + 2;
    if (io) k += full;
    if (rdy_at >= 0) k += 3;
    chk("hold_ic", ic_data, last_ic);
    chk("hold_ls", ls_rdata, last_ls);
    exp = 32'h0;
    for (int i = 0; i < n; i++) begin
      idx = fold(addr + 32'(i));
      if (st) ref_mem[idx] = wdata[8*i +: 8];
      else    exp |= 32'(ref_mem[idx]) << (8*i);
    end
    for (int i = 0; i < 16; i++) trace[i] = 32'h0;
    wr_log.delete();
    writing = st;
    if (is_ic) begin
      ic_req = 1'b1; ic_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    end
    io_buffer_full = (full > 0);
    rdy = (rdy_at != 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      rdy = !(rdy_at >= 0 && cyc >= rdy_at && cyc < rdy_at + 3);
      if (cyc > full) io_buffer_full = 1'b0;
      flush = fl;
      #1;
      if (cyc < 16) trace[cyc] = mem_a;
      seen = is_ic ? ic_done : ls_done;
    end
    ic_req = 1'b0; ls_req = 1'b0; flush = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    chk("latency", cyc, k);
    if (st) begin
      chk("wr_count", wr_log.size(), n);
      for (int i = 0; i < n && i < wr_log.size(); i++) begin
        chk("wr_addr", wr_log[i][39:8], addr + 32'(i));
        chk("wr_data", 32'(wr_log[i][7:0]), 32'(wdata[8*i +: 8]));
      end
    end else begin
      chk(is_ic ? "ic_data" : "ls_rdata", is_ic ? ic_data : ls_rdata, exp);
      if (rdy_at < 0)
        for (int i = 0; i < n; i++) chk("rd_addr", trace[1+i], addr + 32'(i));
      if (is_ic) last_ic = exp;
      else       last_ls = exp;
    end
    @(posedge clk); #1;
    chk("done_pulse", 32'({ic_done, ls_done}), 32'h0);
    writing = 1'b0;
  endtask

  initial begin
    int          cyc, dn, n, kb, full, rdy_at;
    int          ev [$];
    bit          is_ic, we;
    logic [1:0]  size, hi;
    logic [31:0] addr, wdata, exp_ls, exp_ic;

    for (int i = 0; i < c_MEMSZ; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    fork
      forever begin
        @(negedge clk);
        if (mem_wr) begin
          ram[fold(mem_a)] = mem_dout;
          wr_log.push_back({mem_a, mem_dout});
          if (!writing || !rdy) stray_wr++;
        end
        a_lat = mem_a;
        @(posedge clk);
        mem_din <= ram[fold(a_lat)];
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_done", 32'({ic_done, ls_done}), 32'h0);
    chk("rst_ic_data", ic_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);

    // Both requesters from reset: expect LS, IC, LS each six cycles apart.
    exp_ls = {ref_mem[fold(32'h403)], ref_mem[fold(32'h402)], ref_mem[fold(32'h401)], ref_mem[fold(32'h400)]};
    exp_ic = {ref_mem[fold(32'h503)], ref_mem[fold(32'h502)], ref_mem[fold(32'h501)], ref_mem[fold(32'h500)]};
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h400;
    ic_req = 1'b1; ic_addr = 32'h500;
    rst = 1'b1;
    cyc = 0;
    while (ev.size() < 3 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (ls_done) begin ev.push_back(0); chk("sim_ls_data", ls_rdata, exp_ls); end
      if (ic_done) begin ev.push_back(1); chk("sim_ic_data", ic_data, exp_ic); end
      ls_req = !ls_done;
      ic_req = !ic_done;
    end
    ls_req = 1'b0; ic_req = 1'b0;
    chk("sim_events", ev.size(), 3);
    if (ev.size() == 3) begin
      chk("sim_order0", ev[0], 0);
      chk("sim_order1", ev[1], 1);
      chk("sim_order2", ev[2], 0);
    end
    chk("sim_cycles", cyc, 18);
    last_ls = exp_ls;
    last_ic = exp_ic;
    @(posedge clk); #1;

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    do_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 0, -1, 1'b0);
    chk("fetch_word", ic_data, 32'h0000_0513);

    preload(32'h2001, 8'hFE); preload(32'h2002, 8'h80);
    do_txn(1'b0, 1'b0, 2'd1, 32'h2001, 32'h0, 0, -1, 1'b0);
    chk("half_load", ls_rdata, 32'h0000_80FE);

    do_txn(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 5, -1, 1'b0);

    // Flush in the middle of an IC fetch, with the fetch withdrawn.
    ic_req = 1'b1; ic_addr = 32'h100;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin flush = 1'b1; ic_req = 1'b0; end
    end
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (ic_done) dn++;
    end
    chk("flush_no_done", dn, 0);
    do_txn(1'b1, 1'b0, 2'd0, 32'h200, 32'h0, 0, -1, 1'b0);

    do_txn(1'b0, 1'b1, 2'd2, 32'h600, 32'hCAFE_F00D, 0, -1, 1'b1);
    do_txn(1'b0, 1'b0, 2'd2, 32'h600, 32'h0, 0, -1, 1'b0);
    chk("flush_store_rb", ls_rdata, 32'hCAFE_F00D);

    do_txn(1'b0, 1'b0, 2'd2, 32'h700, 32'h0, 0, 2, 1'b0);
    do_txn(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      is_ic = ($urandom_range(0, 3) == 0);
      we    = !is_ic && ($urandom_range(0, 1) == 1);
      size  = 2'($urandom_range(0, 3));
      hi    = 2'($urandom_range(0, 3));
      addr  = {14'h0, hi, 4'h0, 12'($urandom)};
      wdata = $urandom;
      n     = is_ic ? 4 : ((size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4);
      kb    = we ? n + 1 : n + 2;
      full  = (we && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      rdy_at = (full == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, kb - 1)) : -1;
      do_txn(is_ic, we, size, addr, wdata, full, rdy_at, 1'b0);
      if (we) do_txn(1'b0, 1'b0, size, addr, 32'h0, 0, -1, 1'b0);
    end

    // Reset in the middle of a word store.
    writing = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h800; ls_wdata = 32'hA5A5_5A5A;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; ls_req = 1'b0;
    @(posedge clk); #1;
    chk("rstwr_mem_a", mem_a, 32'h0);
    chk("rstwr_mem_dout", 32'(mem_dout), 32'h0);
    chk("rstwr_mem_wr", 32'(mem_wr), 32'h0);
    chk("rstwr_done", 32'({ic_done, ls_done}), 32'h0);
    chk("rstwr_ic_data", ic_data, 32'h0);
    chk("rstwr_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b1;
    writing = 1'b0;
    @(posedge clk); #1;
    chk("stray_wr", stray_wr, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
